// File: rtl/cpu_pkg.sv
// Shared CPU definitions: CSR map, CSR operation codes and CSR FSM states.
// Imported by the CSR unit and its cycle counter.
package cpu_pkg;

    localparam int unsigned CSR_MSTATUS = 0;
    localparam int unsigned CSR_MIE     = 1;
    localparam int unsigned CSR_MIP     = 2;
    localparam int unsigned CSR_MEPC    = 3;
    localparam int unsigned CSR_MCAUSE  = 4;
    localparam int unsigned CSR_MCYCLE  = 5;
    localparam int unsigned CSR_MCYCLEH = 6;
    localparam int unsigned CSR_MTVEC   = 8;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned IRQ_BIT      = 11;

    typedef enum logic [1:0] {
        CSR_NONE  = 2'd0,
        CSR_WRITE = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } csr_op_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } csr_state_e;

endpackage

// File: rtl/csr_cycle_counter.sv
// Double-width free-running cycle counter.
// Either half can be loaded; a load cycle suppresses the increment.
module csr_cycle_counter
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_lo,
    input  logic              load_hi,
    input  logic              inc,
    input  logic [XLEN-1:0]   load_data,
    output logic [2*XLEN-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load_lo) begin
            count[XLEN-1:0] <= load_data;
        end else if (load_hi) begin
            count[2*XLEN-1:XLEN] <= load_data;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file with trap entry, interrupt take and mret return.
// TRAP is a single-cycle state that drives the redirect to the trap vector.
module csr_unit
    import cpu_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              CSR_COUNT   = 16,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h40000100
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [1:0]                   csr_op,
    input  logic [$clog2(CSR_COUNT)-1:0] csr_index,
    input  logic [XLEN-1:0]              csr_wdata,
    output logic [XLEN-1:0]              csr_rdata,
    input  logic                         trap_valid,
    input  logic [XLEN-1:0]              trap_pc,
    input  logic [XLEN-1:0]              trap_cause,
    input  logic                         mret,
    input  logic                         irq_in,
    output logic                         redirect,
    output logic [XLEN-1:0]              redirect_pc,
    output logic                         busy
);

    localparam int IW = $clog2(CSR_COUNT);

    localparam logic [XLEN-1:0] IRQ_CAUSE =
        {1'b1, (XLEN-1)'(IRQ_BIT)};

    logic [XLEN-1:0]   regs [CSR_COUNT];
    logic [2*XLEN-1:0] cycle;
    logic [XLEN-1:0]   mip;
    logic [XLEN-1:0]   new_val;
    logic              irq_q;
    csr_state_e        state;

    logic in_run;
    logic irq_take;
    logic trap_take;
    logic mret_take;
    logic op_take;
    logic sel_mip;
    logic sel_lo;
    logic sel_hi;

    assign sel_mip = csr_index == IW'(CSR_MIP);
    assign sel_lo  = csr_index == IW'(CSR_MCYCLE);
    assign sel_hi  = csr_index == IW'(CSR_MCYCLEH);

    always_comb begin
        mip          = '0;
        mip[IRQ_BIT] = irq_q;
    end

    assign in_run   = state == ST_RUN;
    assign irq_take = in_run && !trap_valid
                    && regs[CSR_MSTATUS][MSTATUS_MIE]
                    && regs[CSR_MIE][IRQ_BIT]
                    && irq_q;
    assign trap_take = in_run && (trap_valid || irq_take);
    assign mret_take = in_run && mret && !trap_take;
    assign op_take   = in_run && !trap_take && !mret
                     && csr_op != CSR_NONE;

    always_comb begin
        csr_rdata = regs[csr_index];
        if (sel_mip) csr_rdata = mip;
        if (sel_lo)  csr_rdata = cycle[XLEN-1:0];
        if (sel_hi)  csr_rdata = cycle[2*XLEN-1:XLEN];
    end

    always_comb begin
        case (csr_op)
            CSR_WRITE: new_val = csr_wdata;
            CSR_SET:   new_val = csr_rdata | csr_wdata;
            CSR_CLEAR: new_val = csr_rdata & ~csr_wdata;
            default:   new_val = csr_rdata;
        endcase
    end

    csr_cycle_counter #(
        .XLEN(XLEN)
    ) u_cycle (
        .clock    (clock),
        .reset    (reset),
        .load_lo  (op_take && sel_lo),
        .load_hi  (op_take && sel_hi),
        .inc      (!(op_take && (sel_lo || sel_hi))),
        .load_data(new_val),
        .count    (cycle)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_in;
            state <= trap_take ? ST_TRAP : ST_RUN;
        end
    end

    // Trap updates come last so they override a same-cycle CSR write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CSR_COUNT; i++) begin
                regs[i] <= (i == CSR_MTVEC) ? MTVEC_RESET : '0;
            end
        end else begin
            if (op_take && !sel_mip && !sel_lo && !sel_hi) begin
                regs[csr_index] <= new_val;
            end
            if (mret_take) begin
                regs[CSR_MSTATUS][MSTATUS_MIE] <=
                    regs[CSR_MSTATUS][MSTATUS_MPIE];
                regs[CSR_MSTATUS][MSTATUS_MPIE] <= 1'b1;
            end
            if (trap_take) begin
                regs[CSR_MEPC]   <= trap_pc;
                regs[CSR_MCAUSE] <= trap_valid ? trap_cause : IRQ_CAUSE;
                regs[CSR_MSTATUS][MSTATUS_MPIE] <=
                    regs[CSR_MSTATUS][MSTATUS_MIE];
                regs[CSR_MSTATUS][MSTATUS_MIE] <= 1'b0;
            end
        end
    end

    assign busy     = state == ST_TRAP;
    assign redirect = busy || mret_take;

    always_comb begin
        redirect_pc = regs[CSR_MEPC];
        if (busy) redirect_pc = {regs[CSR_MTVEC][XLEN-1:2], 2'b00};
    end

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: reset table, modify-op vectors,
// trap / interrupt / mret sequences, counter wrap and mid-trap reset.
module tb_csr_unit;
    import cpu_pkg::*;

    logic        clock;
    logic        reset;
    logic [1:0]  csr_op;
    logic [3:0]  csr_index;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic        mret;
    logic        irq_in;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        busy;

    csr_unit dut (
        .clock      (clock),
        .reset      (reset),
        .csr_op     (csr_op),
        .csr_index  (csr_index),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .trap_valid (trap_valid),
        .trap_pc    (trap_pc),
        .trap_cause (trap_cause),
        .mret       (mret),
        .irq_in     (irq_in),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  idx;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    exp_t sb[$];
    int   n_checks;
    int   n_pass;

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h",
                      name, act, exp);
    endtask

    task automatic push(string name, logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic pop_rd();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check(e.name, csr_rdata, e.val);
        end
    endtask

    task automatic idle();
        csr_op     = CSR_NONE;
        csr_wdata  = '0;
        trap_valid = 1'b0;
        trap_pc    = '0;
        trap_cause = '0;
        mret       = 1'b0;
    endtask

    // Inputs change at the falling edge; the rising edge samples them.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic rd(string name, logic [3:0] idx,
                      logic [31:0] exp);
        csr_index = idx;
        push(name, exp);
        #1;
        pop_rd();
    endtask

    task automatic wr(logic [3:0] idx, logic [31:0] d);
        csr_op    = CSR_WRITE;
        csr_index = idx;
        csr_wdata = d;
        step();
        idle();
    endtask

    vec_t vt[8];

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b0;
        irq_in    = 1'b0;
        csr_index = '0;
        idle();

        vt[0] = '{CSR_WRITE, 4'd9,  32'h0000F0F0, 32'h0000F0F0};
        vt[1] = '{CSR_SET,   4'd9,  32'h0000000F, 32'h0000F0FF};
        vt[2] = '{CSR_CLEAR, 4'd9,  32'h000000F0, 32'h0000F00F};
        vt[3] = '{CSR_WRITE, 4'd10, 32'hAAAA5555, 32'hAAAA5555};
        vt[4] = '{CSR_WRITE, 4'd2,  32'hFFFFFFFF, 32'h00000000};
        vt[5] = '{CSR_SET,   4'd1,  32'h00000800, 32'h00000800};
        vt[6] = '{CSR_WRITE, 4'd8,  32'h40000103, 32'h40000103};
        vt[7] = '{CSR_CLEAR, 4'd10, 32'hFFFF0000, 32'h00005555};

        step();
        step();
        for (int i = 0; i < 16; i++) begin
            rd($sformatf("reset_idx%0d", i), 4'(i),
               (i == 8) ? 32'h40000100 : 32'h0);
        end
        check("reset_redirect", {31'd0, redirect}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        reset = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            if (i != 5)
                rd($sformatf("post_reset_idx%0d", i), 4'(i),
                   (i == 8) ? 32'h40000100 : 32'h0);
        end

        for (int i = 0; i < 8; i++) begin
            csr_op    = vt[i].op;
            csr_index = vt[i].idx;
            csr_wdata = vt[i].wdata;
            push($sformatf("vec%0d", i), vt[i].exp);
            step();
            idle();
            #1;
            pop_rd();
        end
        wr(4'd1, 32'h0);

        trap_valid = 1'b1;
        trap_pc    = 32'h100;
        trap_cause = 32'd2;
        csr_op     = CSR_WRITE;
        csr_index  = 4'd3;
        csr_wdata  = 32'hDEAD;
        step();
        idle();
        csr_op     = CSR_WRITE;
        csr_index  = 4'd9;
        csr_wdata  = 32'h1234;
        trap_valid = 1'b1;
        mret       = 1'b1;
        #1;
        check("trap_redirect", {31'd0, redirect}, 32'd1);
        check("trap_busy", {31'd0, busy}, 32'd1);
        check("trap_vector", redirect_pc, 32'h40000100);
        step();
        idle();
        #1;
        check("trap_end_redirect", {31'd0, redirect}, 32'd0);
        check("trap_end_busy", {31'd0, busy}, 32'd0);
        rd("trap_mepc", 4'd3, 32'h100);
        rd("trap_mcause", 4'd4, 32'd2);
        rd("trap_mstatus", 4'd0, 32'h0);
        rd("trap_write_dropped", 4'd9, 32'h0000F00F);

        wr(4'd0, 32'h8);
        wr(4'd1, 32'h800);
        irq_in  = 1'b1;
        trap_pc = 32'h200;
        #1;
        check("irq_not_yet", {31'd0, redirect}, 32'd0);
        step();
        trap_pc = 32'h200;
        rd("mip_set", 4'd2, 32'h800);
        step();
        trap_pc = '0;
        irq_in  = 1'b0;
        #1;
        check("irq_busy", {31'd0, busy}, 32'd1);
        check("irq_vector", redirect_pc, 32'h40000100);
        step();
        rd("irq_mcause", 4'd4, 32'h8000000B);
        rd("irq_mepc", 4'd3, 32'h200);
        rd("irq_mstatus", 4'd0, 32'h80);
        mret = 1'b1;
        #1;
        check("mret_redirect", {31'd0, redirect}, 32'd1);
        check("mret_pc", redirect_pc, 32'h200);
        step();
        idle();
        #1;
        check("mret_redirect_off", {31'd0, redirect}, 32'd0);
        rd("mret_mstatus", 4'd0, 32'h88);

        irq_in = 1'b1;
        step();
        trap_valid = 1'b1;
        trap_pc    = 32'h300;
        trap_cause = 32'd5;
        mret       = 1'b1;
        #1;
        check("simul_no_mret", {31'd0, redirect}, 32'd0);
        step();
        idle();
        irq_in = 1'b0;
        step();
        rd("simul_mcause", 4'd4, 32'd5);
        rd("simul_mepc", 4'd3, 32'h300);
        rd("simul_mstatus", 4'd0, 32'h80);

        wr(4'd5, 32'hFFFFFFFF);
        wr(4'd6, 32'h0);
        rd("cnt_lo_held", 4'd5, 32'hFFFFFFFF);
        rd("cnt_hi_loaded", 4'd6, 32'h0);
        step();
        rd("cnt_wrap_lo", 4'd5, 32'h0);
        rd("cnt_wrap_hi", 4'd6, 32'h1);
        step();
        rd("cnt_inc", 4'd5, 32'h1);

        trap_valid = 1'b1;
        trap_cause = 32'd7;
        step();
        idle();
        #1;
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("abort_redirect", {31'd0, redirect}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        step();
        reset = 1'b1;
        #1;
        check("abort_no_pulse0", {31'd0, redirect}, 32'd0);
        step();
        check("abort_no_pulse1", {31'd0, redirect}, 32'd0);
        rd("abort_mtvec", 4'd8, 32'h40000100);
        rd("abort_mcause", 4'd4, 32'h0);
        rd("abort_scratch", 4'd9, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
